// File: rtl/arbiter_race_capture.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_race_capture
// Description : Arbiter-PUF race measurement. Launches an edge into two delay
//               chains, decides which synchronized chain output arrived first,
//               measures the arrival margin and reports the result over a
//               valid/ready handshake, then waits for both chains to settle.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_race_capture #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200,
    parameter int SETTLE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             path_a,
    input  logic             path_b,
    output logic             launch,
    output logic             busy,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_bit,
    output logic             resp_tie,
    output logic             resp_timeout,
    output logic [CNT_W-1:0] resp_margin
);

    localparam int RC_W = $clog2(TIMEOUT + 1);
    localparam int SC_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RACE    = 2'd1,
        RELEASE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic a_s1, a_s2, b_s1, b_s2;
    logic flag_a, flag_b, win_a, tie, tmo, launch_r;
    logic [RC_W-1:0]  phase_cnt;
    logic [SC_W-1:0]  settle_cnt;
    logic [CNT_W-1:0] margin;

    // Arrival seen either from an earlier cycle (sticky flag) or right now.
    logic seen_a, seen_b, first_now, both_seen, phase_last, paths_low, settle_done;
    assign seen_a      = flag_a | a_s2;
    assign seen_b      = flag_b | b_s2;
    assign first_now   = !flag_a && !flag_b && (a_s2 || b_s2);
    assign both_seen   = seen_a && seen_b;
    assign phase_last  = (phase_cnt == RC_W'(TIMEOUT - 1));
    assign paths_low   = !a_s2 && !b_s2;
    assign settle_done = paths_low && (settle_cnt == SC_W'(SETTLE - 1));

    // Identical two-stage synchronizers so both chains see equal latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= path_a;
            a_s2 <= a_s1;
            b_s1 <= path_b;
            b_s2 <= b_s1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RACE;
            RACE:    if (both_seen || phase_last) state_nx = RELEASE;
            RELEASE: if (settle_done || phase_last) state_nx = REPORT;
            REPORT:  if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Race bookkeeping: launch, arrival flags, winner, margin, phase counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch_r   <= 1'b0;
            flag_a     <= 1'b0;
            flag_b     <= 1'b0;
            win_a      <= 1'b0;
            tie        <= 1'b0;
            tmo        <= 1'b0;
            margin     <= '0;
            phase_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        launch_r   <= 1'b1;
                        flag_a     <= 1'b0;
                        flag_b     <= 1'b0;
                        win_a      <= 1'b0;
                        tie        <= 1'b0;
                        tmo        <= 1'b0;
                        margin     <= '0;
                        phase_cnt  <= '0;
                        settle_cnt <= '0;
                    end
                end
                RACE: begin
                    flag_a <= seen_a;
                    flag_b <= seen_b;
                    if (first_now) begin
                        win_a <= a_s2 && !b_s2;
                        tie   <= a_s2 && b_s2;
                    end
                    // Count every cycle in which exactly one chain has arrived.
                    if ((seen_a ^ seen_b) && (margin != {CNT_W{1'b1}}))
                        margin <= margin + CNT_W'(1);
                    if (both_seen || phase_last) begin
                        launch_r   <= 1'b0;
                        phase_cnt  <= '0;
                        settle_cnt <= '0;
                        if (!both_seen) tmo <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + RC_W'(1);
                    end
                end
                RELEASE: begin
                    settle_cnt <= paths_low ? settle_cnt + SC_W'(1) : '0;
                    phase_cnt  <= phase_cnt + RC_W'(1);
                    if (phase_last && !settle_done) tmo <= 1'b1;
                end
                REPORT: begin
                    if (resp_ready) begin
                        flag_a <= 1'b0;
                        flag_b <= 1'b0;
                        win_a  <= 1'b0;
                        tie    <= 1'b0;
                        tmo    <= 1'b0;
                        margin <= '0;
                    end
                end
                default: launch_r <= 1'b0;
            endcase
        end
    end

    assign launch       = launch_r;
    assign busy         = (state != IDLE);
    assign resp_valid   = (state == REPORT);
    assign resp_bit     = resp_valid && win_a;
    assign resp_tie     = resp_valid && tie;
    assign resp_timeout = resp_valid && tmo;
    assign resp_margin  = resp_valid ? margin : '0;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_race_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_race_capture
// Description : Self-checking bench for arbiter_race_capture. Instance 0 uses
//               TIMEOUT=200, instance 1 uses TIMEOUT=400. A "drive cycle" d
//               means the chain output goes high d cycles after launch rose;
//               the synced arrival is then seen at race count d+2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_race_capture;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] st, pa, pb, rdy;
    logic [1:0] lau, bsy, vld, rb, rt, ro;
    logic [1:0][7:0] mar;

    int nt = 0;
    int nf = 0;

    always #5 clk = ~clk;

    arbiter_race_capture #(.CNT_W(8), .TIMEOUT(200), .SETTLE(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .path_a(pa[0]), .path_b(pb[0]),
        .launch(lau[0]), .busy(bsy[0]), .resp_valid(vld[0]), .resp_ready(rdy[0]),
        .resp_bit(rb[0]), .resp_tie(rt[0]), .resp_timeout(ro[0]), .resp_margin(mar[0])
    );

    arbiter_race_capture #(.CNT_W(8), .TIMEOUT(400), .SETTLE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .path_a(pa[1]), .path_b(pb[1]),
        .launch(lau[1]), .busy(bsy[1]), .resp_valid(vld[1]), .resp_ready(rdy[1]),
        .resp_bit(rb[1]), .resp_tie(rt[1]), .resp_timeout(ro[1]), .resp_margin(mar[1])
    );

    typedef struct {
        int da;
        int db;
        bit gl;
        bit eb;
        bit et;
        bit eo;
        int em;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        nt++;
        if (act != exp) begin
            nf++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: result derived directly from arrival times and the rules.
    task automatic model(input int da, input int db, input int tmo,
                         output bit eb, output bit et, output bit eo, output int em);
        int ta, tb;
        ta = (da < 0) ? -1 : da + 2;
        tb = (db < 0) ? -1 : db + 2;
        if (ta >= tmo) ta = -1;
        if (tb >= tmo) tb = -1;
        eb = 0; et = 0; eo = 0; em = 0;
        if (ta >= 0 && tb >= 0) begin
            if (ta == tb) et = 1;
            else begin
                eb = (ta < tb);
                em = (ta < tb) ? tb - ta : ta - tb;
            end
        end else if (ta >= 0) begin
            eo = 1; eb = 1; em = tmo - ta;
        end else if (tb >= 0) begin
            eo = 1; em = tmo - tb;
        end else begin
            eo = 1;
        end
        if (em > 255) em = 255;
    endtask

    task automatic run_race(input int s, input int da, input int db, input bit gl,
                            input int h, input int exp_lat, input bit chk_launch,
                            input int tmo, input bit hs, input bit eb, input bit et,
                            input bit eo, input int em, input string nm);
        int c;
        int lat;
        @(negedge clk);
        st[s] = 1'b1;
        @(negedge clk);
        st[s] = 1'b0;
        c = 0;
        while (c < 1000) begin
            if (!lau[s]) break;
            pa[s] = (da >= 0) && (gl ? (c == da) : (c >= da));
            pb[s] = (db >= 0) && (c >= db);
            c++;
            @(negedge clk);
        end
        if (c >= 1000) begin
            check({nm, "_launch_stuck"}, c, 0);
            pa[s] = 1'b0;
            pb[s] = 1'b0;
            return;
        end
        if (chk_launch) check({nm, "_launch_cycles"}, c, tmo);
        for (int i = 0; i < h && !vld[s]; i++) @(negedge clk);
        if (exp_lat >= 0) check({nm, "_valid_during_hold"}, int'(vld[s]), 0);
        pa[s] = 1'b0;
        pb[s] = 1'b0;
        lat = 0;
        while (!vld[s] && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_valid"}, int'(vld[s]), 1);
        if (!vld[s]) return;
        if (exp_lat >= 0) check({nm, "_settle_latency"}, lat, exp_lat);
        check({nm, "_launch_low"}, int'(lau[s]), 0);
        check({nm, "_busy"}, int'(bsy[s]), 1);
        check({nm, "_bit"}, int'(rb[s]), int'(eb));
        check({nm, "_tie"}, int'(rt[s]), int'(et));
        check({nm, "_timeout"}, int'(ro[s]), int'(eo));
        check({nm, "_margin"}, int'(mar[s]), em);
        if (hs) begin
            rdy[s] = 1'b1;
            @(negedge clk);
            rdy[s] = 1'b0;
            check({nm, "_post_valid"}, int'(vld[s]), 0);
            check({nm, "_post_busy"}, int'(bsy[s]), 0);
            check({nm, "_post_margin"}, int'(mar[s]), 0);
            check({nm, "_post_bit"}, int'(rb[s]), 0);
            repeat (4) @(negedge clk);
        end
    endtask

    vec_t vt[10];

    initial begin
        bit eb, et, eo;
        int em, da, db;
        bit gl;

        vt[0] = '{da: 1,   db: 5,  gl: 0, eb: 1, et: 0, eo: 0, em: 4};
        vt[1] = '{da: 7,   db: 0,  gl: 0, eb: 0, et: 0, eo: 0, em: 7};
        vt[2] = '{da: 3,   db: 3,  gl: 0, eb: 0, et: 1, eo: 0, em: 0};
        vt[3] = '{da: -1,  db: -1, gl: 0, eb: 0, et: 0, eo: 1, em: 0};
        vt[4] = '{da: 0,   db: -1, gl: 0, eb: 1, et: 0, eo: 1, em: 198};
        vt[5] = '{da: -1,  db: 10, gl: 0, eb: 0, et: 0, eo: 1, em: 188};
        vt[6] = '{da: 4,   db: 20, gl: 1, eb: 1, et: 0, eo: 0, em: 16};
        vt[7] = '{da: 197, db: -1, gl: 0, eb: 1, et: 0, eo: 1, em: 1};
        vt[8] = '{da: 198, db: -1, gl: 0, eb: 0, et: 0, eo: 1, em: 0};
        vt[9] = '{da: 0,   db: 0,  gl: 0, eb: 0, et: 1, eo: 0, em: 0};

        rst_n = 1'b0;
        st = '0; pa = '0; pb = '0; rdy = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_launch%0d", s), int'(lau[s]), 0);
            check($sformatf("reset_busy%0d", s), int'(bsy[s]), 0);
            check($sformatf("reset_valid%0d", s), int'(vld[s]), 0);
            check($sformatf("reset_resp%0d", s), int'({rb[s], rt[s], ro[s]}), 0);
            check($sformatf("reset_margin%0d", s), int'(mar[s]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1 with extended release hold: settle latency is sync + SETTLE.
        run_race(0, vt[0].da, vt[0].db, 0, 5, 6, 0, 200, 1,
                 vt[0].eb, vt[0].et, vt[0].eo, vt[0].em, "s1");

        // Table of directed races on the TIMEOUT=200 instance.
        for (int i = 0; i < 10; i++)
            run_race(0, vt[i].da, vt[i].db, vt[i].gl, 0, -1, vt[i].eo, 200, 1,
                     vt[i].eb, vt[i].et, vt[i].eo, vt[i].em, $sformatf("vec%0d", i));

        // Release phase timeout: chains stay high long after launch fell.
        run_race(0, 0, 0, 0, 250, -1, 0, 200, 1, 0, 1, 1, 0, "rel_tmo");

        // Randomized races against the reference model.
        for (int i = 0; i < 24; i++) begin
            da = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 60));
            db = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 60));
            gl = (da >= 0) && ($urandom_range(0, 3) == 0);
            model(da, db, 200, eb, et, eo, em);
            run_race(0, da, db, gl, 0, -1, 0, 200, 1, eb, et, eo, em,
                     $sformatf("rnd%0d_a%0d_b%0d", i, da, db));
        end

        // Saturated margin on the TIMEOUT=400 instance, then held response.
        model(0, 298, 400, eb, et, eo, em);
        check("sat_model_margin", em, 255);
        run_race(1, 0, 298, 0, 0, -1, 0, 400, 0, 1, 0, 0, 255, "sat");
        for (int i = 0; i < 10; i++) begin
            st[1] = (i % 2 == 0);
            @(negedge clk);
            check($sformatf("hold%0d_valid", i), int'(vld[1]), 1);
            check($sformatf("hold%0d_launch", i), int'(lau[1]), 0);
            check($sformatf("hold%0d_resp", i), int'({rb[1], rt[1], ro[1]}), 4);
            check($sformatf("hold%0d_margin", i), int'(mar[1]), 255);
        end
        st[1] = 1'b0;
        rdy[1] = 1'b1;
        @(negedge clk);
        rdy[1] = 1'b0;
        check("sat_post_valid", int'(vld[1]), 0);
        check("sat_post_busy", int'(bsy[1]), 0);
        @(negedge clk);
        check("sat_no_relaunch", int'(lau[1]), 0);

        // Asynchronous reset in the middle of a race.
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_race_launch", int'(lau[0]), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_launch", int'(lau[0]), 0);
        check("async_rst_busy", int'(bsy[0]), 0);
        check("async_rst_valid", int'(vld[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_race(0, vt[0].da, vt[0].db, 0, 5, 6, 0, 200, 1,
                 vt[0].eb, vt[0].et, vt[0].eo, vt[0].em, "s1_after_rst");

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter_race_capture.md
Name: arbiter_race_capture

Overview:
- Measurement end of the Arbiter-PUF delay path.
- On start, raises a launch edge that feeds the two delay chains built from process_delay_model instances.
- Watches both chain outputs, decides which arrived first, and reports the response bit, arrival margin and tie/timeout flags over a valid/ready handshake.
- Then drops launch and waits for both chains to settle low before accepting the next challenge.

Parameters:
CNT_W, 8, width of resp_margin; margin saturates at 2^CNT_W-1
TIMEOUT, 200, max cycles allowed per phase (race, release) before abort
SETTLE, 4, consecutive cycles both synced paths must read low to end release

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a race; sampled only in IDLE
path_a  input  1  output of delay chain A (asynchronous level)
path_b  input  1  output of delay chain B (asynchronous level)
launch  output  1  race edge driven into both chains
busy  output  1  high in every state except IDLE
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_bit  output  1  1 = A first, 0 = B first, tie or no arrival
resp_tie  output  1  both arrived in the same sampled cycle
resp_timeout  output  1  a phase hit TIMEOUT
resp_margin  output  CNT_W  cycles between first and second arrival

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: launch=0, busy=0, resp_valid=0, resp_bit=0, resp_tie=0, resp_timeout=0, resp_margin=0.
  - Internal state: FSM=IDLE; synchronizers, counters and arrival flags cleared.
  - Applies immediately, including mid-race; launch falls without waiting for a clock edge.
- Synchronization:
  - path_a and path_b each pass through an identical 2-FF synchronizer, so both paths see equal latency.
  - All decisions use the synced values.
- States:
  - IDLE: start=1 -> RACE; launch registered high on that edge. start in any other state is ignored.
  - RACE:
    - launch=1; race counter increments each cycle from 0.
    - Arrival flags are sticky; a flag sets the first cycle its synced path reads 1.
    - When the first flag sets: record winner and begin the margin count. The margin increments each cycle until the other flag sets, saturating at 2^CNT_W-1.
    - Both flags set -> RELEASE.
    - Race counter reaches TIMEOUT first -> set timeout flag, -> RELEASE.
  - RELEASE:
    - launch=0.
    - Settle counter counts consecutive cycles with both synced paths low and resets on any high.
    - Reaches SETTLE -> REPORT.
    - TIMEOUT cycles spent in RELEASE -> set timeout flag, -> REPORT.
  - REPORT:
    - resp_valid=1; resp_* outputs held stable while resp_ready=0.
    - On resp_valid&&resp_ready, on that edge: resp_valid=0, outputs cleared, -> IDLE.
    - resp_ready ignored outside REPORT.
- Result rules:
  - A strictly first: resp_bit=1.
  - B strictly first: resp_bit=0.
  - Same cycle: resp_tie=1, resp_bit=0, margin=0.
  - Neither arrived: resp_timeout=1, resp_bit=0, margin=0.
  - Exactly one arrived: resp_timeout=1, resp_bit=winner, margin=saturated count at abort.
  - Glitch low after arrival does not clear the arrival flag.
- Timing:
  - Zero-delay chains give a minimum race of 2 cycles after launch, due to synchronizer latency.
  - The race counter is sized ceil(log2(TIMEOUT+1)) bits, independent of CNT_W.

Test Plan:
1. start; path_a rises 3 cycles after launch, path_b 7 -> resp_bit=1, resp_margin=4, tie=0, timeout=0; launch falls; resp_valid only after both paths low for 4 cycles.
2. path_b at 2, path_a at 9 -> resp_bit=0, resp_margin=7; handshake with resp_ready=1 returns to IDLE, busy=0 next cycle.
3. Both paths rise at cycle 5 -> resp_tie=1, resp_bit=0, resp_margin=0.
4. Neither path rises -> launch held exactly 200 cycles, then resp_timeout=1, margin=0. Second case, path_a at 2 only -> resp_bit=1, resp_timeout=1, resp_margin=198.
5. TIMEOUT=400, path_a at 2, path_b at 300 -> resp_margin=255 (saturated), timeout=0. Then hold resp_ready=0 for 10 cycles while pulsing start -> all resp_* stable, no new launch.
6. Assert rst_n=0 mid-RACE -> launch, busy and resp_valid go 0 without a clock edge. Release reset, issue scenario 1 -> identical result.
